// File: rtl/tensor_core_host_sequencer.sv
// tensor_core_host_sequencer
//   Host-side driver for the tensor core cpu instruction port. Accepts a job
//   (operation select + 18 operand bytes), issues cpu reset / burst write /
//   operate / wait / burst read on instruction_out, captures the 18 result
//   bytes from cpu_output_in and returns them as nine 16-bit stream words.
// Ports:
//   clock_in, reset_in (async, active-low)
//   start_in, operation_select_in, ready_out       : job request
//   operand_valid_in, operand_data_in, operand_ready_out : 9 operand words
//   instruction_out, cpu_output_in                 : cpu instruction port
//   result_valid_out, result_data_out, result_ready_in   : 9 result words
//   hazard_out                                     : sticky payload hazard
module tensor_core_host_sequencer #(
  parameter int unsigned OPERATE_WAIT_CYCLES = 8,
  parameter int unsigned WRITE_BEATS         = 5,
  parameter int unsigned READ_BEATS          = 9
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic [2:0]  operation_select_in,
  output logic        ready_out,
  input  logic        operand_valid_in,
  input  logic [15:0] operand_data_in,
  output logic        operand_ready_out,
  output logic [15:0] instruction_out,
  input  logic [7:0]  cpu_output_in,
  output logic        result_valid_out,
  output logic [15:0] result_data_out,
  input  logic        result_ready_in,
  output logic        hazard_out
);

  localparam logic [15:0] INSTR_NOP       = 16'h0000;
  localparam logic [15:0] INSTR_CPU_RESET = 16'h000C;
  localparam logic [15:0] INSTR_WR_HDR    = 16'h0007;
  localparam logic [15:0] INSTR_RD_HDR    = 16'h0003;
  localparam int unsigned WAIT_W = (OPERATE_WAIT_CYCLES > 1) ? $clog2(OPERATE_WAIT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_INIT_RESET, S_IDLE, S_LOAD, S_WR_HDR, S_WR_DATA,
    S_OP, S_WAIT, S_RD_HDR, S_RD_DATA, S_DRAIN
  } state_t;

  state_t              state;
  logic [15:0]         instr_q;
  logic [3:0]          cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [2:0]          op_sel;
  logic [15:0]         w [0:8];
  logic [15:0]         r [0:8];
  logic [7:0]          neg_byte;

  logic [3:0]          even_idx, odd_idx, next_odd_idx;
  logic [15:0]         even_word, odd_word, next_odd_word;

  // w[9] is the padding word and always reads as zero.
  assign even_idx     = {cnt[2:0], 1'b0};
  assign odd_idx      = {cnt[2:0], 1'b1};
  assign next_odd_idx = {cnt[2:0] + 3'd1, 1'b1};

  always_comb begin
    even_word     = (even_idx     > 4'd8) ? '0 : w[even_idx];
    odd_word      = (odd_idx      > 4'd8) ? '0 : w[odd_idx];
    next_odd_word = (next_odd_idx > 4'd8) ? '0 : w[next_odd_idx];
  end

  // During the burst the cpu takes one word per clock edge, so the data word
  // follows the clock level: even word while high (negedge capture), odd word
  // while low (posedge capture).
  assign instruction_out = (state == S_WR_DATA) ? (clock_in ? even_word : odd_word) : instr_q;
  assign result_data_out = (cnt > 4'd8) ? '0 : r[cnt];

  // Low nibble 1100 on a posedge-sampled word is decoded by the cpu as reset.
  function automatic logic is_hazard(input logic [15:0] word);
    return word[3:0] == 4'b1100;
  endfunction

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state             <= S_INIT_RESET;
      instr_q           <= INSTR_NOP;
      ready_out         <= 1'b0;
      operand_ready_out <= 1'b0;
      result_valid_out  <= 1'b0;
      hazard_out        <= 1'b0;
      cnt               <= '0;
      wait_cnt          <= '0;
      op_sel            <= '0;
    end else begin
      case (state)
        S_INIT_RESET: begin
          // First cycle after release shows NOP, next one the cpu reset word.
          if (instr_q == INSTR_CPU_RESET) begin
            instr_q   <= INSTR_NOP;
            ready_out <= 1'b1;
            state     <= S_IDLE;
          end else begin
            instr_q <= INSTR_CPU_RESET;
          end
        end
        S_IDLE: begin
          if (start_in && ready_out) begin
            op_sel            <= operation_select_in;
            hazard_out        <= 1'b0;
            cnt               <= '0;
            ready_out         <= 1'b0;
            operand_ready_out <= 1'b1;
            state             <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (operand_valid_in && operand_ready_out) begin
            if (cnt == 4'd8) begin
              cnt               <= '0;
              operand_ready_out <= 1'b0;
              instr_q           <= INSTR_WR_HDR;
              state             <= S_WR_HDR;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_WR_HDR: begin
          hazard_out <= hazard_out | is_hazard(w[1]);
          cnt        <= '0;
          instr_q    <= INSTR_NOP;
          state      <= S_WR_DATA;
        end
        S_WR_DATA: begin
          if (cnt == 4'(WRITE_BEATS - 1)) begin
            cnt     <= '0;
            instr_q <= {11'b0, op_sel, 2'b10};
            state   <= S_OP;
          end else begin
            // Flag is raised on entry to the beat that carries the word.
            hazard_out <= hazard_out | is_hazard(next_odd_word);
            cnt        <= cnt + 4'd1;
          end
        end
        S_OP: begin
          instr_q  <= INSTR_NOP;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_W'(OPERATE_WAIT_CYCLES - 1)) begin
            instr_q <= INSTR_RD_HDR;
            state   <= S_RD_HDR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RD_HDR: begin
          instr_q <= INSTR_NOP;
          cnt     <= '0;
          state   <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (cnt == 4'(READ_BEATS - 1)) begin
            cnt              <= '0;
            result_valid_out <= 1'b1;
            state            <= S_DRAIN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (result_ready_in) begin
            if (cnt == 4'(READ_BEATS - 1)) begin
              cnt              <= '0;
              result_valid_out <= 1'b0;
              ready_out        <= 1'b1;
              state            <= S_IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= S_INIT_RESET;
      endcase
    end
  end

  // Data buffers carry no reset; contents are only meaningful within a job.
  always_ff @(posedge clock_in) begin
    if (state == S_LOAD && operand_valid_in && operand_ready_out)
      w[cnt] <= operand_data_in;
    if (state == S_RD_DATA)
      r[cnt] <= {neg_byte, cpu_output_in};
  end

  always_ff @(negedge clock_in) begin
    if (state == S_RD_DATA)
      neg_byte <= cpu_output_in;
  end

endmodule

// File: tb/tb_tensor_core_host_sequencer.sv
// Testbench for tensor_core_host_sequencer: drives jobs, acts as the cpu on
// the read side, checks the instruction stream and scoreboards result words.
module tb_tensor_core_host_sequencer;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        start_in = 1'b0;
  logic [2:0]  operation_select_in = '0;
  logic        ready_out;
  logic        operand_valid_in = 1'b0;
  logic [15:0] operand_data_in = '0;
  logic        operand_ready_out;
  logic [15:0] instruction_out;
  logic [7:0]  cpu_output_in = '0;
  logic        result_valid_out;
  logic [15:0] result_data_out;
  logic        result_ready_in = 1'b0;
  logic        hazard_out;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] job_w [0:9];
  logic [15:0] mon_exp;

  tensor_core_host_sequencer #(
    .OPERATE_WAIT_CYCLES(8),
    .WRITE_BEATS(5),
    .READ_BEATS(9)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .start_in(start_in),
    .operation_select_in(operation_select_in),
    .ready_out(ready_out),
    .operand_valid_in(operand_valid_in),
    .operand_data_in(operand_data_in),
    .operand_ready_out(operand_ready_out),
    .instruction_out(instruction_out),
    .cpu_output_in(cpu_output_in),
    .result_valid_out(result_valid_out),
    .result_data_out(result_data_out),
    .result_ready_in(result_ready_in),
    .hazard_out(hazard_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout exp=event at %0t", name, $time);
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clock_in) begin
    if (result_valid_out && result_ready_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_extra got=%h exp=none at %0t", result_data_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", result_data_out, mon_exp);
      end
    end
  end

  task automatic reset_values();
    chk("rst_instr", instruction_out, 16'h0000);
    chk("rst_ready", {15'b0, ready_out}, 16'h0000);
    chk("rst_op_ready", {15'b0, operand_ready_out}, 16'h0000);
    chk("rst_res_valid", {15'b0, result_valid_out}, 16'h0000);
    chk("rst_hazard", {15'b0, hazard_out}, 16'h0000);
  endtask

  task automatic release_and_init();
    @(posedge clock_in); #1 reset_in = 1'b1;
    @(posedge clock_in); #1;
    chk("init_cpu_reset", instruction_out, 16'h000C);
    chk("init_ready_lo", {15'b0, ready_out}, 16'h0000);
    @(posedge clock_in); #1;
    chk("init_nop", instruction_out, 16'h0000);
    chk("init_ready_hi", {15'b0, ready_out}, 16'h0001);
  endtask

  task automatic run_job(input logic [2:0] op, input logic [7:0] base,
                         input int stall, input bit abort);
    logic hz;
    bit   ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock_in);
      if (ready_out) begin ok = 1'b1; break; end
    end
    if (!ok) begin fail_timeout("wait_ready"); return; end
    #1 start_in = 1'b1; operation_select_in = op;
    @(posedge clock_in); #1 start_in = 1'b0;
    if (!abort)
      for (int k = 0; k < 9; k++)
        exp_q.push_back({base + 8'(2 * k), base + 8'(2 * k + 1)});
    chk("accept_hazard_clr", {15'b0, hazard_out}, 16'h0000);

    for (int i = 0; i < 9; i++) begin
      operand_valid_in = 1'b1;
      operand_data_in  = job_w[i];
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clock_in);
        if (operand_ready_out) begin ok = 1'b1; break; end
      end
      if (!ok) begin fail_timeout("operand_ready"); operand_valid_in = 1'b0; return; end
      @(posedge clock_in); #1;
    end
    operand_valid_in = 1'b0;
    chk("wr_hdr", instruction_out, 16'h0007);

    hz = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock_in); #1;
      hz = hz | (job_w[2 * k + 1][3:0] == 4'b1100);
      chk("wr_even", instruction_out, job_w[2 * k]);
      chk("hazard", {15'b0, hazard_out}, {15'b0, hz});
      @(negedge clock_in); #1;
      chk("wr_odd", instruction_out, job_w[2 * k + 1]);
    end
    @(posedge clock_in); #1;
    chk("operate", instruction_out, {11'b0, op, 2'b10});

    for (int i = 0; i < 8; i++) begin
      @(posedge clock_in); #1;
      chk("wait_nop", instruction_out, 16'h0000);
      if (abort && i == 3) begin
        #2 reset_in = 1'b0;
        #1 reset_values();
        exp_q.delete();
        release_and_init();
        return;
      end
    end
    @(posedge clock_in); #1;
    chk("rd_hdr", instruction_out, 16'h0003);

    for (int k = 0; k < 9; k++) begin
      @(posedge clock_in); #1 cpu_output_in = base + 8'(2 * k);
      @(negedge clock_in); #1 cpu_output_in = base + 8'(2 * k + 1);
    end
    @(posedge clock_in); #1;
    chk("drain_valid", {15'b0, result_valid_out}, 16'h0001);
    for (int s = 0; s < stall; s++) begin
      chk("stall_hold", result_data_out, {base, base + 8'd1});
      @(posedge clock_in); #1;
    end
    result_ready_in = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clock_in); #1;
    end
    result_ready_in = 1'b0;
    if (!ok) begin fail_timeout("drain_done"); return; end
    chk("end_ready", {15'b0, ready_out}, 16'h0001);
    chk("end_valid", {15'b0, result_valid_out}, 16'h0000);
    chk("hazard_sticky", {15'b0, hazard_out}, {15'b0, hz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0;
    repeat (3) @(posedge clock_in);
    #1 reset_values();
    release_and_init();

    // Job 1: bytes 1..18, op 0; word 5 (0B0C) is a hazard at beat 2.
    for (int i = 0; i < 9; i++) job_w[i] = {8'(2 * i + 1), 8'(2 * i + 2)};
    job_w[9] = 16'h0000;
    run_job(3'b000, 8'h10, 5, 1'b0);

    // Job 2: hazard word 000C at index 1, op 5.
    for (int i = 0; i < 9; i++) job_w[i] = {8'h20 + 8'(2 * i), 8'h21 + 8'(2 * i)};
    job_w[1] = 16'h000C;
    run_job(3'b101, 8'hA0, 0, 1'b0);

    // Job 3: same operands, reset pulsed during WAIT.
    run_job(3'b010, 8'h70, 0, 1'b1);

    // Job 4: no hazard words, short stall.
    for (int i = 0; i < 9; i++) job_w[i] = {8'h40 + 8'(i), 8'h80 + 8'(i)};
    run_job(3'b011, 8'h50, 2, 1'b0);

    repeat (2) @(posedge clock_in);
    #1 chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
